// File: rtl/tsc_phase_sequencer_if.sv
// rtl/tsc_phase_sequencer_if.sv - sensor inputs and lamp outputs of the phase sequencer
// TSC_PREEMPT_EN adds the preempt input.
interface tsc_phase_sequencer_if;
    logic       x;
    logic       ped_req;
`ifdef TSC_PREEMPT_EN
    logic       preempt;
`endif
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       ped_walk;
    logic [2:0] phase;

`ifdef TSC_PREEMPT_EN
    modport master (output x, ped_req, preempt, input hwy, cntry, ped_walk, phase);
    modport slave  (input x, ped_req, preempt, output hwy, cntry, ped_walk, phase);
`else
    modport master (output x, ped_req, input hwy, cntry, ped_walk, phase);
    modport slave  (input x, ped_req, output hwy, cntry, ped_walk, phase);
`endif
endinterface

// File: rtl/tsc_phase_sequencer.sv
// rtl/tsc_phase_sequencer.sv - timed highway/country phase sequencer, Moore FSM with dwell counter
// Optional feature: TSC_PREEMPT_EN (preempt input holds HG and cuts CG short).
module tsc_phase_sequencer #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned HG_MIN  = 8,
    parameter int unsigned Y_TIME  = 3,
    parameter int unsigned AR_TIME = 2,
    parameter int unsigned CG_MIN  = 3,
    parameter int unsigned CG_MAX  = 6
) (
    input  logic                  clk,
    input  logic                  clear_n,
    tsc_phase_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    localparam logic [CNT_W-1:0] HG_LAST     = CNT_W'(HG_MIN - 1);
    localparam logic [CNT_W-1:0] Y_LAST      = CNT_W'(Y_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(AR_TIME - 1);
    localparam logic [CNT_W-1:0] CG_MIN_LAST = CNT_W'(CG_MIN - 1);
    localparam logic [CNT_W-1:0] CG_MAX_LAST = CNT_W'(CG_MAX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_pend_q, ped_pend_d;
    logic             preempt_w;
    logic [1:0]       hwy_w, cntry_w;
    logic             walk_w;

`ifdef TSC_PREEMPT_EN
    assign preempt_w = bus.preempt;
`else
    assign preempt_w = 1'b0;
`endif

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= HG;
            cnt_q      <= '0;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HG:  if (!preempt_w && cnt_q >= HG_LAST && (bus.x || ped_pend_q)) state_d = HY;
            HY:  if (cnt_q == Y_LAST)  state_d = AR1;
            AR1: if (cnt_q == AR_LAST) state_d = CG;
            // CG_MAX cap keeps the highway from starving under continuous country traffic
            CG:  if (preempt_w || cnt_q == CG_MAX_LAST || (cnt_q >= CG_MIN_LAST && !bus.x))
                     state_d = CY;
            CY:  if (cnt_q == Y_LAST)  state_d = AR2;
            AR2: if (cnt_q == AR_LAST) state_d = HG;
            default: state_d = HG;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Entering CG serves the request, so the clear beats a same-cycle press
    always_comb begin
        ped_pend_d = ped_pend_q | bus.ped_req;
        if (state_q == AR1 && state_d == CG) begin
            ped_pend_d = 1'b0;
        end
    end

    always_comb begin
        hwy_w   = LAMP_RED;
        cntry_w = LAMP_RED;
        walk_w  = 1'b0;
        case (state_q)
            HG:  hwy_w = LAMP_GREEN;
            HY:  hwy_w = LAMP_YELLOW;
            CG: begin
                cntry_w = LAMP_GREEN;
                walk_w  = 1'b1;
            end
            CY:  cntry_w = LAMP_YELLOW;
            default: begin
                hwy_w   = LAMP_RED;
                cntry_w = LAMP_RED;
            end
        endcase
    end

    assign bus.hwy      = hwy_w;
    assign bus.cntry    = cntry_w;
    assign bus.ped_walk = walk_w;
    assign bus.phase    = state_q;

endmodule
